// File: rtl/ws2812_pixel_stream_encoder_if.sv
// Pixel stream handshake between the pixel fetch logic (master) and the WS2812 encoder (slave).
interface ws2812_pixel_stream_encoder_if #(
    parameter int PIXEL_BITS = 24
);
    logic [PIXEL_BITS-1:0] pixel_data;
    logic                  pixel_last;
    logic                  pixel_valid;
    logic                  pixel_ready;

    modport master (
        output pixel_data,
        output pixel_last,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_last,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/ws2812_pixel_stream_encoder.sv
// WS2812 line encoder: double-buffered pixel stream in, MSB-first return-to-zero pulses out,
// with an automatic latch/reset low window at end of frame or when the stream runs dry.
module ws2812_pixel_stream_encoder #(
    parameter int CLK_FREQ_KHZ  = 10000,
    parameter int T_HI_TRUE_NS  = 700,
    parameter int T_HI_FALSE_NS = 300,
    parameter int T_PERIOD_NS   = 1100,
    parameter int T_RESET_NS    = 80000,
    parameter int PIXEL_BITS    = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ws2812_pixel_stream_encoder_if.slave  pixel,
    output logic                          encoded_output,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          underrun
);

    localparam int CLK_PERIOD_NS    = 1000000 / CLK_FREQ_KHZ;
    localparam int T_HI_TRUE_TICKS  = T_HI_TRUE_NS / CLK_PERIOD_NS;
    localparam int T_HI_FALSE_TICKS = T_HI_FALSE_NS / CLK_PERIOD_NS;
    localparam int T_PERIOD_TICKS   = T_PERIOD_NS / CLK_PERIOD_NS;
    localparam int T_RESET_TICKS    = T_RESET_NS / CLK_PERIOD_NS;

    localparam int TICK_MAX = (T_PERIOD_TICKS > T_RESET_TICKS) ? T_PERIOD_TICKS : T_RESET_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);
    localparam int BW       = $clog2(PIXEL_BITS + 1);

    localparam logic [TW-1:0] PERIOD_LAST = TW'(T_PERIOD_TICKS - 1);
    localparam logic [TW-1:0] RESET_LAST  = TW'(T_RESET_TICKS - 1);
    localparam logic [TW-1:0] HI_TRUE     = TW'(T_HI_TRUE_TICKS);
    localparam logic [TW-1:0] HI_FALSE    = TW'(T_HI_FALSE_TICKS);
    localparam logic [BW-1:0] BIT_LAST    = BW'(PIXEL_BITS - 1);

    generate
        if (T_HI_FALSE_TICKS < 1) begin : g_chk_hi_false
            $error("T_HI_FALSE_TICKS must be at least 1");
        end
        if (T_HI_TRUE_TICKS <= T_HI_FALSE_TICKS) begin : g_chk_hi_true
            $error("T_HI_TRUE_TICKS must exceed T_HI_FALSE_TICKS");
        end
        if (T_PERIOD_TICKS <= T_HI_TRUE_TICKS) begin : g_chk_period
            $error("T_PERIOD_TICKS must exceed T_HI_TRUE_TICKS");
        end
        if (T_RESET_TICKS < 1) begin : g_chk_reset
            $error("T_RESET_TICKS must be at least 1");
        end
        if (PIXEL_BITS < 1) begin : g_chk_bits
            $error("PIXEL_BITS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_RESET
    } state_t;

    state_t                state_reg;
    logic [PIXEL_BITS-1:0] buf_data_reg;
    logic                  buf_last_reg;
    logic                  buf_full_reg;
    logic [PIXEL_BITS-1:0] shift_data_reg;
    logic                  shift_last_reg;
    logic [BW-1:0]         bit_reg;
    logic [TW-1:0]         tick_reg;
    logic [TW-1:0]         hi_ticks;
    logic                  accept;

    // Ready depends only on the holding buffer, so a refill and a drain never share an edge.
    assign pixel.pixel_ready = rst_n && !buf_full_reg;
    assign accept            = pixel.pixel_valid && pixel.pixel_ready;
    assign hi_ticks          = shift_data_reg[PIXEL_BITS-1] ? HI_TRUE : HI_FALSE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            buf_data_reg   <= '0;
            buf_last_reg   <= 1'b0;
            buf_full_reg   <= 1'b0;
            shift_data_reg <= '0;
            shift_last_reg <= 1'b0;
            bit_reg        <= '0;
            tick_reg       <= '0;
            encoded_output <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            busy       <= (state_reg != ST_IDLE);

            if (accept) begin
                buf_data_reg <= pixel.pixel_data;
                buf_last_reg <= pixel.pixel_last;
                buf_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    encoded_output <= 1'b0;
                    if (buf_full_reg) begin
                        shift_data_reg <= buf_data_reg;
                        shift_last_reg <= buf_last_reg;
                        buf_full_reg   <= 1'b0;
                        tick_reg       <= '0;
                        bit_reg        <= '0;
                        state_reg      <= ST_TX;
                    end
                end

                ST_TX: begin
                    encoded_output <= (tick_reg < hi_ticks);
                    if (tick_reg == PERIOD_LAST) begin
                        tick_reg <= '0;
                        if (bit_reg == BIT_LAST) begin
                            // End of pixel: frame end wins over a waiting pixel.
                            if (shift_last_reg) begin
                                state_reg <= ST_RESET;
                            end else if (buf_full_reg) begin
                                shift_data_reg <= buf_data_reg;
                                shift_last_reg <= buf_last_reg;
                                buf_full_reg   <= 1'b0;
                                bit_reg        <= '0;
                            end else begin
                                underrun  <= 1'b1;
                                state_reg <= ST_RESET;
                            end
                        end else begin
                            shift_data_reg <= shift_data_reg << 1;
                            bit_reg        <= bit_reg + BW'(1);
                        end
                    end else begin
                        tick_reg <= tick_reg + TW'(1);
                    end
                end

                ST_RESET: begin
                    encoded_output <= 1'b0;
                    if (tick_reg == RESET_LAST) begin
                        frame_done <= 1'b1;
                        tick_reg   <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        tick_reg <= tick_reg + TW'(1);
                    end
                end

                default: begin
                    encoded_output <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_stream_encoder.sv
// Directed bench for the WS2812 pixel stream encoder: default RGB instance plus a 32-bit, 20 MHz instance.
module tb_ws2812_pixel_stream_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enc24, busy24, fd24, ur24;
    logic enc32, busy32, fd32, ur32;

    ws2812_pixel_stream_encoder_if #(.PIXEL_BITS(24)) pix24 ();
    ws2812_pixel_stream_encoder_if #(.PIXEL_BITS(32)) pix32 ();

    ws2812_pixel_stream_encoder dut24 (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel          (pix24),
        .encoded_output (enc24),
        .busy           (busy24),
        .frame_done     (fd24),
        .underrun       (ur24)
    );

    ws2812_pixel_stream_encoder #(
        .CLK_FREQ_KHZ (20000),
        .PIXEL_BITS   (32)
    ) dut32 (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel          (pix32),
        .encoded_output (enc32),
        .busy           (busy32),
        .frame_done     (fd32),
        .underrun       (ur32)
    );

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    logic [32:0] feed_q[$];

    // Pulse/level counters for the 24-bit instance; checks use differences between snapshots.
    int busy_cnt = 0;
    int fd_cnt   = 0;
    int ur_cnt   = 0;
    always @(negedge clk) begin
        if (busy24) busy_cnt++;
        if (fd24)   fd_cnt++;
        if (ur24)   ur_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_enc();   return sel != 0 ? enc32 : enc24;   endfunction
    function automatic logic get_busy();  return sel != 0 ? busy32 : busy24; endfunction
    function automatic logic get_fd();    return sel != 0 ? fd32 : fd24;     endfunction
    function automatic logic get_ur();    return sel != 0 ? ur32 : ur24;     endfunction
    function automatic logic get_ready(); return sel != 0 ? pix32.pixel_ready : pix24.pixel_ready; endfunction

    task automatic feed_update();
        logic [32:0] w;
        pix24.pixel_valid = 1'b0;
        pix32.pixel_valid = 1'b0;
        if (feed_q.size() > 0) begin
            w = feed_q[0];
            if (sel != 0) begin
                pix32.pixel_data  = w[31:0];
                pix32.pixel_last  = w[32];
                pix32.pixel_valid = 1'b1;
            end else begin
                pix24.pixel_data  = w[23:0];
                pix24.pixel_last  = w[32];
                pix24.pixel_valid = 1'b1;
            end
        end
    endtask

    task automatic push(input logic last, input logic [31:0] data);
        feed_q.push_back({last, data});
        feed_update();
    endtask

    task automatic step();
        logic fire;
        fire = (sel != 0) ? (pix32.pixel_valid && pix32.pixel_ready)
                          : (pix24.pixel_valid && pix24.pixel_ready);
        @(posedge clk);
        #1;
        if (fire) void'(feed_q.pop_front());
        feed_update();
    endtask

    // One check per bit period: the sampled line pattern against hi cycles of 1 then low.
    task automatic tx_pixel(input string tag, input logic [31:0] word, input int nbits,
                            input int hi1, input int hi0, input int period);
        for (int b = 0; b < nbits; b++) begin
            logic [31:0] obs;
            logic [31:0] exp;
            logic        bitv;
            obs  = '0;
            exp  = '0;
            bitv = word[nbits-1-b];
            for (int t = 0; t < period; t++) begin
                step();
                obs = {obs[30:0], get_enc()};
                exp = {exp[30:0], (t < (bitv ? hi1 : hi0))};
            end
            check($sformatf("%s bit%0d", tag, b), 64'(obs), 64'(exp));
        end
        $display("tx %s: pixel 0x%0h, %0d bits", tag, word, nbits);
    endtask

    task automatic reset_window(input string tag, input int n, output logic rdy_last);
        int highs;
        int early_fd;
        highs    = 0;
        early_fd = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (get_enc()) highs++;
            if (i < n - 1 && get_fd()) early_fd++;
        end
        rdy_last = get_ready();
        check({tag, " reset window low"}, 64'(highs), 64'(0));
        check({tag, " frame_done early"}, 64'(early_fd), 64'(0));
        check({tag, " frame_done last"}, 64'(get_fd()), 64'(1));
        step();
        check({tag, " busy drop"}, 64'(get_busy()), 64'(0));
        check({tag, " frame_done single"}, 64'(get_fd()), 64'(0));
        $display("reset %s: %0d low cycles, frame_done seen", tag, n);
    endtask

    initial begin
        int b0, f0, u0, highs;
        logic rdy;

        rst_n = 1'b0;
        pix24.pixel_data = '0; pix24.pixel_last = 1'b0; pix24.pixel_valid = 1'b0;
        pix32.pixel_data = '0; pix32.pixel_last = 1'b0; pix32.pixel_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst enc", 64'(enc24), 64'(0));
        check("rst busy", 64'(busy24), 64'(0));
        check("rst frame_done", 64'(fd24), 64'(0));
        check("rst underrun", 64'(ur24), 64'(0));
        check("rst ready24", 64'(pix24.pixel_ready), 64'(0));
        check("rst ready32", 64'(pix32.pixel_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        check("release ready24", 64'(pix24.pixel_ready), 64'(1));
        check("release ready32", 64'(pix32.pixel_ready), 64'(1));

        // Single pixel 0xA00000, last: 7H4L 3H8L 7H4L then 21x 3H8L
        b0 = busy_cnt; f0 = fd_cnt; u0 = ur_cnt;
        push(1'b1, 32'h00A0_0000);
        step();
        check("t1 ready after accept", 64'(pix24.pixel_ready), 64'(0));
        check("t1 busy before load", 64'(busy24), 64'(0));
        step();
        check("t1 ready after drain", 64'(pix24.pixel_ready), 64'(1));
        check("t1 enc before first bit", 64'(enc24), 64'(0));
        tx_pixel("t1", 32'h00A0_0000, 24, 7, 3, 11);
        reset_window("t1", 800, rdy);
        check("t1 busy cycles", 64'(busy_cnt - b0), 64'(24 * 11 + 800));
        check("t1 frame_done pulses", 64'(fd_cnt - f0), 64'(1));
        check("t1 underrun pulses", 64'(ur_cnt - u0), 64'(0));

        // Three back-to-back pixels, last on the third
        b0 = busy_cnt; f0 = fd_cnt; u0 = ur_cnt;
        push(1'b0, 32'h00FF_FFFF);
        push(1'b0, 32'h0000_0000);
        push(1'b1, 32'h000F_0F0F);
        step();
        step();
        tx_pixel("t2 p0", 32'h00FF_FFFF, 24, 7, 3, 11);
        tx_pixel("t2 p1", 32'h0000_0000, 24, 7, 3, 11);
        tx_pixel("t2 p2", 32'h000F_0F0F, 24, 7, 3, 11);
        check("t2 no underrun at end", 64'(ur24), 64'(0));
        reset_window("t2", 800, rdy);
        check("t2 busy cycles", 64'(busy_cnt - b0), 64'(72 * 11 + 800));
        check("t2 frame_done pulses", 64'(fd_cnt - f0), 64'(1));
        check("t2 underrun pulses", 64'(ur_cnt - u0), 64'(0));

        // Underrun on a non-last pixel, then a pixel offered during the reset window
        f0 = fd_cnt; u0 = ur_cnt;
        push(1'b0, 32'h0012_3456);
        step();
        step();
        tx_pixel("t3", 32'h0012_3456, 24, 7, 3, 11);
        check("t3 underrun pulse", 64'(ur24), 64'(1));
        push(1'b1, 32'h0080_0001);
        reset_window("t3", 800, rdy);
        check("t4 held during reset", 64'(rdy), 64'(0));
        check("t4 ready after drain", 64'(pix24.pixel_ready), 64'(1));
        check("t4 enc before first bit", 64'(enc24), 64'(0));
        tx_pixel("t4", 32'h0080_0001, 24, 7, 3, 11);
        reset_window("t4", 800, rdy);
        check("t3/t4 underrun pulses", 64'(ur_cnt - u0), 64'(1));
        check("t3/t4 frame_done pulses", 64'(fd_cnt - f0), 64'(2));

        // Reset asserted at tick 3 of bit 5 with the buffer full
        push(1'b0, 32'h00FF_FFFF);
        push(1'b1, 32'h0000_AA55);
        step();
        step();
        repeat (58) step();
        check("t5 enc high before reset", 64'(enc24), 64'(1));
        check("t5 buffer full before reset", 64'(pix24.pixel_ready), 64'(0));
        f0 = fd_cnt;
        rst_n = 1'b0;
        #1;
        check("t5 enc cleared", 64'(enc24), 64'(0));
        check("t5 busy cleared", 64'(busy24), 64'(0));
        check("t5 ready low in reset", 64'(pix24.pixel_ready), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("t5 ready after release", 64'(pix24.pixel_ready), 64'(1));
        highs = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (enc24 || busy24) highs++;
        end
        check("t5 nothing sent after reset", 64'(highs), 64'(0));
        check("t5 no frame_done", 64'(fd_cnt - f0), 64'(0));
        $display("reset t5: mid-frame reset discarded pending pixel");

        // 32-bit pixels at 20 MHz: 22-tick period, 14/6 highs, 1600-cycle reset
        sel = 1;
        push(1'b1, 32'h8000_0001);
        step();
        step();
        check("t6 enc before first bit", 64'(enc32), 64'(0));
        tx_pixel("t6", 32'h8000_0001, 32, 14, 6, 22);
        check("t6 no underrun", 64'(ur32), 64'(0));
        reset_window("t6", 1600, rdy);
        sel = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_stream_encoder.md
# ws2812_pixel_stream_encoder

Parametrised WS2812-family line encoder. It accepts whole pixel words over a valid/ready stream and serialises them MSB-first as unipolar return-to-zero pulses. It double-buffers so consecutive pixels go out back-to-back with no gap, and it emits the latch/reset low period on its own at end of frame or on underrun. It sits between the frame/pixel fetch logic and the LED data pin, and supersedes the per-bit command-driven encoder.

## Interface
- CLK_FREQ_KHZ, 10000: clock frequency; CLK_PERIOD_NS = 1e6 / CLK_FREQ_KHZ (integer).
- T_HI_TRUE_NS, 700: high time of a 1 bit.
- T_HI_FALSE_NS, 300: high time of a 0 bit.
- T_PERIOD_NS, 1100: total bit period.
- T_RESET_NS, 80000: latch/reset low time.
- PIXEL_BITS, 24: bits per pixel (24 for RGB, 32 for RGBW).
- Derived tick counts are each NS value / CLK_PERIOD_NS, truncated: T_HI_TRUE_TICKS, T_HI_FALSE_TICKS, T_PERIOD_TICKS, T_RESET_TICKS.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_data  in  PIXEL_BITS  pixel word, transmitted MSB first.
- pixel_last  in  1  marks the last pixel of a frame; captured together with pixel_data.
- pixel_valid  in  1  upstream has a pixel.
- pixel_ready  out  1  equals rst_n && !buf_full; a transfer happens when valid && ready at a rising edge.
- encoded_output  out  1  registered RZ line output.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse on the RESET→IDLE transition.
- underrun  out  1  one-cycle pulse when the shifter runs dry mid-frame.

## Operation
- Storage:
  - One holding buffer: data, last flag, buf_full.
  - One shift register: data, last flag.
  - Bit counter sized for PIXEL_BITS.
  - Tick counter sized for max(T_PERIOD_TICKS, T_RESET_TICKS).
- States: IDLE, TX, RESET.
- IDLE:
  - encoded_output = 0.
  - If buf_full: move the buffer into the shifter, clear buf_full, set tick = 0 and bit = 0, go to TX.
- TX:
  - Each cycle: encoded_output <= (tick < hi_ticks), where hi_ticks = T_HI_TRUE_TICKS if the current MSB is 1, else T_HI_FALSE_TICKS.
  - tick increments and wraps at T_PERIOD_TICKS-1, then the shifter shifts left and bit increments.
  - At the last tick of bit PIXEL_BITS-1, in this priority order:
    - Shifter last flag set: go to RESET with tick = 0.
    - Else buf_full: load the next pixel into the shifter (bit = 0, tick = 0) and stay in TX. The next bit's first high cycle follows immediately, with no gap.
    - Else: pulse underrun and go to RESET with tick = 0.
- RESET:
  - encoded_output = 0 for T_RESET_TICKS cycles.
  - On the final cycle, pulse frame_done and go to IDLE.
- The buffer accepts a pixel in any state, including RESET. A pixel accepted during RESET is held until the transition to IDLE and then transmitted.
- Because pixel_ready = !buf_full, accept and drain never happen on the same edge.
- Elaboration error (via $error in a generate check) when any of these fails:
  - T_HI_FALSE_TICKS ≥ 1
  - T_HI_TRUE_TICKS > T_HI_FALSE_TICKS
  - T_PERIOD_TICKS > T_HI_TRUE_TICKS
  - T_RESET_TICKS ≥ 1
  - PIXEL_BITS ≥ 1

## Timing
- Reset values:
  - encoded_output = 0, busy = 0, frame_done = 0, underrun = 0.
  - pixel_ready = 0 while rst_n is low; it goes to 1 combinationally when rst_n releases.
  - State IDLE, buf_full = 0, counters = 0.
- Latency from idle:
  - Pixel accepted at edge N.
  - IDLE loads the shifter at edge N+1.
  - encoded_output first goes high at edge N+2.
- Pixel streaming:
  - Bit period is exactly T_PERIOD_TICKS cycles; pixel period is PIXEL_BITS × T_PERIOD_TICKS cycles.
  - pixel_ready rises the cycle after the buffer drains into the shifter, giving upstream a full pixel period to refill.
- End of frame: the reset window is exactly T_RESET_TICKS cycles of low output after the final bit period. frame_done is high in the last of those cycles, and busy drops on the following edge.
- Reset asserted mid-frame:
  - All state clears immediately; encoded_output drops at once without finishing the bit.
  - No reset window and no frame_done are emitted, and buffer contents are discarded.
  - Downstream LEDs latch only after the required low time, which software must guarantee.

## Test plan
- Defaults (period 11, hi 7/3, reset 800 ticks). Single pixel 0xA00000, last=1 -> bits are 7H4L, 3H8L, 7H4L, then 21× 3H8L. Then 800 low cycles, one frame_done pulse, busy high for 24×11+800 cycles.
- Three pixels 0xFFFFFF, 0x000000, 0x0F0F0F offered back-to-back with last on the third -> 72 contiguous bit periods with no extra low cycles, one reset window, one frame_done, underrun never asserted.
- One pixel with last=0 and no follow-up -> after 24 bits underrun pulses once, then 800 low cycles and frame_done.
- Pixel offered during RESET -> accepted (ready then 0), held; its first high edge comes 2 cycles after the frame_done cycle.
- rst_n low at tick 3 of bit 5 with the buffer full -> encoded_output, busy and pixel_ready go 0 immediately. After release: ready = 1, output stays 0, no frame_done, the discarded pixel is never sent.
- PIXEL_BITS=32, CLK_FREQ_KHZ=20000 -> 22-tick period, 14/6-tick highs, 32 bits per pixel, 1600-cycle reset.
